// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for loads and stores
//   - FSM state enum (IDLE, REQ, DONE)
//   - helpers for alignment and store byte enables
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memState_e;

    // Access size is carried in funct3[1:0]: 00 byte, 01 half, 1x word.
    function automatic logic isAligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b00:   isAligned = 1'b1;
            2'b01:   isAligned = ~lane[0];
            default: isAligned = (lane == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byteEnable(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b00:   byteEnable = 4'b0001 << lane;
            2'b01:   byteEnable = 4'b0011 << lane;
            default: byteEnable = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load-data formatter.
//   rdata  : 32-bit word read from the data bus
//   lane   : byte offset of the access within the word
//   funct3 : load type (B, H, W, BU, HU)
//   result : selected lane, sign- or zero-extended to 32 bits
module load_extender
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            F3_W:    result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Takes the EX->MEM access, runs one req/ack
// transaction on the data bus and stalls the front of the pipeline until it
// completes.
//   clk, reset                     : clock, synchronous active-high reset
//   ALUOutM, StoreCounterOutM      : byte address, right-justified store data
//   ALUSelectM[2:0]                : funct3 (access size / signedness)
//   MemReadM, MemWriteM            : load / store present in MEM
//   mem_req/we/addr/wdata/be       : bus request fields, stable while mem_req
//   mem_ack, mem_rdata             : one-cycle completion and read word
//   StallM                         : freezes IF..EX and the EX/MEM register
//   LoadDataW, LoadValidW          : extended load result and its pulse
//   MisalignM, BusErrM             : dropped-access / timeout / illegal pulses
//   stateDbg                       : current FSM state
// Valid/ready: a request is offered while mem_req is high with all fields held
// constant; the transfer completes on the single cycle mem_ack is high, and
// any mem_ack seen outside REQ is ignored.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] StoreCounterOutM,
    input  logic [5:0]  ALUSelectM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] LoadDataW,
    output logic        LoadValidW,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic [1:0]  stateDbg
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    memState_e   state;
    logic [15:0] timeoutCnt;
    logic [2:0]  funct3Q;
    logic [1:0]  laneQ;
    logic        isLoadQ;
    logic        errQ;
    logic [31:0] extData;

    logic access, illegal, aligned, startAccess, inIdle;
    logic unusedSelBits;

    assign unusedSelBits = ^ALUSelectM[5:3];

    assign access      = MemReadM | MemWriteM;
    assign illegal     = MemReadM & MemWriteM;
    assign aligned     = isAligned(ALUSelectM[2:0], ALUOutM[1:0]);
    assign startAccess = access & ~illegal & aligned;
    assign inIdle      = (state == IDLE) & ~reset;

    // Stall is combinational in IDLE so the EX/MEM register holds the access
    // on the very cycle it is detected. Reset forces every output low.
    assign StallM     = ~reset & (((state == IDLE) & startAccess) | (state == REQ));
    assign MisalignM  = inIdle & access & ~illegal & ~aligned;
    assign BusErrM    = (inIdle & illegal) | (~reset & (state == DONE) & errQ);
    assign LoadValidW = ~reset & (state == DONE) & isLoadQ & ~errQ;
    assign stateDbg   = state;

    load_extender u_loadExtender (
        .rdata  (mem_rdata),
        .lane   (laneQ),
        .funct3 (funct3Q),
        .result (extData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timeoutCnt <= 16'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            funct3Q    <= 3'b000;
            laneQ      <= 2'b00;
            isLoadQ    <= 1'b0;
            errQ       <= 1'b0;
            LoadDataW  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    errQ <= 1'b0;
                    if (startAccess) begin
                        state      <= REQ;
                        timeoutCnt <= 16'h0;
                        mem_req    <= 1'b1;
                        mem_we     <= MemWriteM;
                        mem_addr   <= {ALUOutM[31:2], 2'b00};
                        mem_be     <= MemWriteM ? byteEnable(ALUSelectM[2:0], ALUOutM[1:0]) : 4'b1111;
                        mem_wdata  <= MemWriteM ? (StoreCounterOutM << {ALUOutM[1:0], 3'b000}) : 32'h0;
                        funct3Q    <= ALUSelectM[2:0];
                        laneQ      <= ALUOutM[1:0];
                        isLoadQ    <= MemReadM;
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (isLoadQ) begin
                            LoadDataW <= extData;
                        end
                    end else if (timeoutCnt == TIMEOUT_LAST) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        errQ      <= 1'b1;
                        LoadDataW <= 32'h0;
                    end else begin
                        timeoutCnt <= timeoutCnt + 16'h1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
